// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS_DLX core: sequences core reset, enables execution,
// counts RUN cycles and zero-flag cycles, and stops on halt or watchdog expiry.
module mips_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 13,
  parameter int CNT_W      = 16,
  parameter int AUTO_START = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             zero,
  input  logic             halt,
  output logic             core_reset,
  output logic             core_en,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] zero_count,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RST_HOLD = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_TIMEOUT  = 3'd4;

  localparam int              HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  WD_LIMIT  = CNT_W'(MAX_CYCLES);
  localparam logic              WD_EN     = (MAX_CYCLES != 0);
  localparam logic              AUTO_EN   = (AUTO_START != 0);

  logic [2:0]        state_r, state_nxt_s;
  logic [HOLD_W-1:0] hold_r, hold_nxt_s;
  logic [CNT_W-1:0]  cyc_r, cyc_nxt_s, cyc_inc_s;
  logic [CNT_W-1:0]  zc_r, zc_nxt_s, zc_inc_s;
  logic              done_nxt_s, timeout_nxt_s;
  logic              core_reset_nxt_s, core_en_nxt_s;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign cyc_inc_s = (cyc_r == CNT_MAX) ? cyc_r : cyc_r + CNT_W'(1);
  assign zc_inc_s  = (zc_r == CNT_MAX) ? zc_r : zc_r + CNT_W'(1);

  assign state       = state_r;
  assign cycle_count = cyc_r;
  assign zero_count  = zc_r;

  // State and registered-output update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      hold_r     <= '0;
      cyc_r      <= '0;
      zc_r       <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      core_reset <= 1'b1;
      core_en    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_r     <= hold_nxt_s;
      cyc_r      <= cyc_nxt_s;
      zc_r       <= zc_nxt_s;
      done       <= done_nxt_s;
      timeout    <= timeout_nxt_s;
      core_reset <= core_reset_nxt_s;
      core_en    <= core_en_nxt_s;
    end
  end

  // Next-state selection; halt takes priority over the watchdog.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (AUTO_EN || start) state_nxt_s = S_RST_HOLD;
        else                  state_nxt_s = S_IDLE;
      end
      S_RST_HOLD: begin
        if (hold_r == HOLD_LAST) state_nxt_s = S_RUN;
        else                     state_nxt_s = S_RST_HOLD;
      end
      S_RUN: begin
        if (halt)                                 state_nxt_s = S_DONE;
        else if (WD_EN && (cyc_inc_s == WD_LIMIT)) state_nxt_s = S_TIMEOUT;
        else                                      state_nxt_s = S_RUN;
      end
      S_DONE, S_TIMEOUT: begin
        if (start) state_nxt_s = S_RST_HOLD;
        else       state_nxt_s = state_r;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of counters, flags and core controls, derived from the upcoming state.
  always_comb begin
    hold_nxt_s    = hold_r;
    cyc_nxt_s     = cyc_r;
    zc_nxt_s      = zc_r;
    done_nxt_s    = done;
    timeout_nxt_s = timeout;
    if ((state_r != S_RST_HOLD) && (state_nxt_s == S_RST_HOLD)) begin
      hold_nxt_s    = '0;
      cyc_nxt_s     = '0;
      zc_nxt_s      = '0;
      done_nxt_s    = 1'b0;
      timeout_nxt_s = 1'b0;
    end else if (state_r == S_RST_HOLD) begin
      if (hold_r != HOLD_LAST) hold_nxt_s = hold_r + HOLD_W'(1);
      else                     hold_nxt_s = hold_r;
    end else if (state_r == S_RUN) begin
      cyc_nxt_s     = cyc_inc_s;
      if (zero) zc_nxt_s = zc_inc_s;
      else      zc_nxt_s = zc_r;
      done_nxt_s    = (state_nxt_s == S_DONE);
      timeout_nxt_s = (state_nxt_s == S_TIMEOUT);
    end else begin
      hold_nxt_s = hold_r;
    end
    core_reset_nxt_s = (state_nxt_s == S_IDLE) || (state_nxt_s == S_RST_HOLD);
    core_en_nxt_s    = (state_nxt_s == S_RUN);
  end

endmodule
